// File: rtl/pe_issue_ctrl.sv
// Issue controller in front of a pipelined butterfly PE: mode-locked issue,
// credit-based 8-entry response FIFO. Watchdog built only with PE_ISSUE_TIMEOUT_EN.
`timescale 1ns/1ps
module pe_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_mode_i,
    input  logic [11:0] req_a_i,
    input  logic [11:0] req_b_i,
    input  logic [11:0] req_w_i,
    output logic [11:0] pe_a0_o,
    output logic [11:0] pe_b0_o,
    output logic [11:0] pe_w0_o,
    output logic [2:0]  pe_ctrl_o,
    output logic        pe_valid_o,
    input  logic [11:0] pe_u0_i,
    input  logic [11:0] pe_v0_i,
    input  logic        pe_valid_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [11:0] rsp_u_o,
    output logic [11:0] rsp_v_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    localparam logic [2:0] PE_MODE_ADDSUB = 3'd0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cur_mode, mode_d;
    logic        live;
    logic [3:0]  inflight;
    logic [3:0]  fifo_count;
    logic [2:0]  wr_ptr, rd_ptr;
    logic [23:0] mem [8];
    logic        credit_ok, mode_match, accept, pe_in, push, pop;

    // live keeps req_ready_o low while reset is asserted
    assign credit_ok  = live && (({1'b0, inflight} + {1'b0, fifo_count}) < 5'd8);
    assign mode_match = (req_mode_i == cur_mode);
    assign accept     = req_valid_i && req_ready_o;
    assign pe_in      = pe_valid_i && (inflight != 4'd0);
    assign push       = pe_in;
    assign pop        = rsp_valid_o && rsp_ready_i;

    // FSM next state, mode capture and request readiness
    always_comb begin
        state_d     = state_q;
        mode_d      = cur_mode;
        req_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = credit_ok;
                if (req_valid_i && credit_ok) begin
                    state_d = RUN;
                    mode_d  = req_mode_i;
                end
            end
            RUN: begin
                req_ready_o = credit_ok && mode_match;
                if (req_valid_i && !mode_match)
                    state_d = DRAIN;
                else if (!req_valid_i && inflight == 4'd0)
                    state_d = IDLE;
            end
            DRAIN: begin
                if (inflight == 4'd0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, current mode and reset-release flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cur_mode <= PE_MODE_ADDSUB;
            live     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_mode <= mode_d;
            live     <= 1'b1;
        end
    end

    // operand registers towards the PE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_a0_o    <= '0;
            pe_b0_o    <= '0;
            pe_w0_o    <= '0;
            pe_valid_o <= 1'b0;
        end else begin
            pe_valid_o <= accept;
            if (accept) begin
                pe_a0_o <= req_a_i;
                pe_b0_o <= req_b_i;
                pe_w0_o <= req_w_i;
            end
        end
    end

    // in-flight counter; stray PE results are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inflight <= '0;
        else if (accept && !pe_in)
            inflight <= inflight + 4'd1;
        else if (!accept && pe_in)
            inflight <= inflight - 4'd1;
    end

    // response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 3'd1;
            if (pop)
                rd_ptr <= rd_ptr + 3'd1;
            if (push && !pop)
                fifo_count <= fifo_count + 4'd1;
            else if (!push && pop)
                fifo_count <= fifo_count - 4'd1;
        end
    end

    // response FIFO storage; credits guarantee a free slot on push
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {pe_u0_i, pe_v0_i};
    end

    assign rsp_valid_o = (fifo_count != 4'd0);
    assign rsp_u_o     = rsp_valid_o ? mem[rd_ptr][23:12] : '0;
    assign rsp_v_o     = rsp_valid_o ? mem[rd_ptr][11:0]  : '0;
    assign pe_ctrl_o   = cur_mode;
    assign busy_o      = (state_q != IDLE) || (inflight != 4'd0) ||
                         (fifo_count != 4'd0);

`ifdef PE_ISSUE_TIMEOUT_EN
    logic [4:0] wd_cnt;
    logic       err_q;

    // watchdog: cycles waiting on the PE with nothing returning
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (pe_valid_i || inflight == 4'd0) begin
            wd_cnt <= '0;
        end else if (wd_cnt != 5'd16) begin
            wd_cnt <= wd_cnt + 5'd1;
            if (wd_cnt == 5'd15)
                err_q <= 1'b1;
        end
    end

    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Randomized bench for pe_issue_ctrl with a behavioural PE and a
// queue-based reference of accepted requests and buffered results.
`timescale 1ns/1ps
module tb_pe_issue_ctrl;

    localparam int Q = 3329;
    localparam logic [2:0] M_ADDSUB = 3'd0;
    localparam logic [2:0] M_CODECO = 3'd1;
    localparam logic [2:0] M_NTT    = 3'd2;
    localparam logic [2:0] M_INTT   = 3'd3;
    localparam logic [2:0] M_CWM    = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_mode_i = 3'd0;
    logic [11:0] req_a_i = '0, req_b_i = '0, req_w_i = '0;
    logic [11:0] pe_a0_o, pe_b0_o, pe_w0_o;
    logic [2:0]  pe_ctrl_o;
    logic        pe_valid_o;
    logic [11:0] pe_u0_i = '0, pe_v0_i = '0;
    logic        pe_valid_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [11:0] rsp_u_o, rsp_v_o;
    logic        busy_o;
    logic        err_timeout_o;

    pe_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_mode_i(req_mode_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_w_i(req_w_i),
        .pe_a0_o(pe_a0_o), .pe_b0_o(pe_b0_o), .pe_w0_o(pe_w0_o),
        .pe_ctrl_o(pe_ctrl_o), .pe_valid_o(pe_valid_o),
        .pe_u0_i(pe_u0_i), .pe_v0_i(pe_v0_i), .pe_valid_i(pe_valid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_u_o(rsp_u_o), .rsp_v_o(rsp_v_o),
        .busy_o(busy_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pe_calc(input logic [2:0] m,
        input logic [11:0] a, input logic [11:0] b, input logic [11:0] w);
        int ia, ib, iw, t, u, v;
        ia = int'(a); ib = int'(b); iw = int'(w);
        case (m)
            M_ADDSUB: begin u = (ia + ib) % Q; v = (ia - ib + Q) % Q; end
            M_NTT: begin
                t = (iw * ib) % Q;
                u = (ia + t) % Q;
                v = (ia - t + Q) % Q;
            end
            M_INTT: begin
                u = (ia + ib) % Q;
                v = (((ia - ib + Q) % Q) * iw) % Q;
            end
            M_CWM: begin u = (ia * ib) % Q; v = (ia * iw) % Q; end
            default: begin u = ia; v = (ia + ib) % Q; end
        endcase
        return {u[11:0], v[11:0]};
    endfunction

    // total accept-to-response latency is pe_lat + 2
    function automatic int pe_lat(input logic [2:0] m);
        if (m == M_ADDSUB) return 1;
        if (m == M_CODECO) return 3;
        return 4;
    endfunction

    // behavioural PE: results scheduled into a timeline by mode latency
    bit          stub = 1'b0;
    bit          slot_v [64];
    logic [23:0] slot_d [64];
    int          cyc_pe = 0;

    always @(posedge clk) begin
        int idx;
        cyc_pe++;
        if (pe_valid_o && !stub) begin
            idx = (cyc_pe + pe_lat(pe_ctrl_o) - 1) % 64;
            slot_v[idx] = 1'b1;
            slot_d[idx] = pe_calc(pe_ctrl_o, pe_a0_o, pe_b0_o, pe_w0_o);
        end
        idx = cyc_pe % 64;
        pe_valid_i <= slot_v[idx];
        pe_u0_i    <= slot_d[idx][23:12];
        pe_v0_i    <= slot_d[idx][11:0];
        slot_v[idx] = 1'b0;
    end

    // reference model state
    logic [23:0] exp_q [$];
    logic [23:0] fifo_q [$];
    int          n_infl = 0;
    logic [2:0]  act_mode = M_ADDSUB;
    bit          prev_acc = 1'b0;
    logic [35:0] prev_ops = '0;
    bit          hold = 1'b0;
    logic [23:0] hold_d = '0;
    bit          last_acc = 1'b0;
    int          acc_infl0 = 0;
    int          cyc = 0;
    int          pops = 0;
    int          first_pop = -1;
    int          last_pop = -1;

    task automatic tick();
        bit acc, pop, pin;
        int infl0;
        #1;
        cyc++;
        infl0 = n_infl;
        check("pe_valid", 64'(pe_valid_o), 64'(prev_acc));
        if (prev_acc)
            check("pe_ops", 64'({pe_a0_o, pe_b0_o, pe_w0_o}), 64'(prev_ops));
        check("rsp_valid", 64'(rsp_valid_o), 64'(fifo_q.size() != 0));
        if (infl0 != 0)
            check("pe_ctrl", 64'(pe_ctrl_o), 64'(act_mode));
        if (hold && rsp_valid_o)
            check("rsp_stable", 64'({rsp_u_o, rsp_v_o}), 64'(hold_d));
        if (req_ready_o)
            check("credit", 64'(infl0 + fifo_q.size() < 8), 64'(1));
        if (req_valid_i && infl0 != 0 && req_mode_i != act_mode)
            check("mode_hold", 64'(req_ready_o), 64'(0));
        acc = req_valid_i && req_ready_o;
        pop = rsp_valid_o && rsp_ready_i;
        pin = pe_valid_i && (infl0 != 0);
        if (pop && fifo_q.size() != 0) begin
            check("rsp_data", 64'({rsp_u_o, rsp_v_o}), 64'(fifo_q.pop_front()));
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (pin) begin
            fifo_q.push_back(exp_q.pop_front());
            n_infl--;
        end
        if (acc) begin
            if (infl0 != 0)
                check("mode_lock", 64'(req_mode_i), 64'(act_mode));
            exp_q.push_back(pe_calc(req_mode_i, req_a_i, req_b_i, req_w_i));
            n_infl++;
            act_mode  = req_mode_i;
            acc_infl0 = infl0;
        end
        last_acc = acc;
        prev_acc = acc;
        prev_ops = {req_a_i, req_b_i, req_w_i};
        hold     = rsp_valid_o && !rsp_ready_i;
        hold_d   = {rsp_u_o, rsp_v_o};
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'(0));
        check("rst_pe_valid", 64'(pe_valid_o), 64'(0));
        check("rst_pe_ops", 64'({pe_a0_o, pe_b0_o, pe_w0_o}), 64'(0));
        check("rst_pe_ctrl", 64'(pe_ctrl_o), 64'(M_ADDSUB));
        check("rst_rsp", 64'({rsp_valid_o, rsp_u_o, rsp_v_o}), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_err", 64'(err_timeout_o), 64'(0));
        exp_q.delete();
        fifo_q.delete();
        n_infl   = 0;
        act_mode = M_ADDSUB;
        prev_acc = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic [2:0] m, input int a, input int b,
                        input int w);
        int n;
        req_valid_i = 1'b1;
        req_mode_i  = m;
        req_a_i = 12'(a); req_b_i = 12'(b); req_w_i = 12'(w);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 60);
        req_valid_i = 1'b0;
        check("send_acc", 64'(last_acc), 64'(1));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        n = 0;
        while ((fifo_q.size() != 0 || n_infl != 0) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(fifo_q.size() + n_infl), 64'(0));
    endtask

    task automatic rand_ops();
        req_a_i = 12'($urandom_range(0, Q - 1));
        req_b_i = 12'($urandom_range(0, Q - 1));
        req_w_i = 12'($urandom_range(0, Q - 1));
    endtask

    initial begin
        int lat, cnt, n, late, p0;
        logic [2:0] rm;
        #2;
        apply_reset();

        // single ADDSUB
        send(M_ADDSUB, 5, 3, 0);
        wait_rsp(lat);
        check("addsub_lat", 64'(lat), 64'(3));
        check("addsub_u", 64'(rsp_u_o), 64'(8));
        check("addsub_v", 64'(rsp_v_o), 64'(2));
        drain("addsub_drain");

        // single NTT butterfly
        send(M_NTT, 1, 2, 3);
        wait_rsp(lat);
        check("ntt_lat", 64'(lat), 64'(6));
        check("ntt_u", 64'(rsp_u_o), 64'(7));
        check("ntt_v", 64'(rsp_v_o), 64'(3324));
        drain("ntt_drain");

        // 20 back-to-back NTT requests
        first_pop = -1;
        p0 = pops;
        cnt = 0;
        req_valid_i = 1'b1;
        req_mode_i  = M_NTT;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            tick();
            if (last_acc) cnt++;
        end
        req_valid_i = 1'b0;
        check("b2b_acc", 64'(cnt), 64'(20));
        drain("b2b_drain");
        check("b2b_pops", 64'(pops - p0), 64'(20));
        check("b2b_span", 64'(last_pop - first_pop), 64'(19));

        // mode switch while NTT results are in flight
        req_valid_i = 1'b1;
        req_mode_i  = M_NTT;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
        end
        req_mode_i = M_ADDSUB;
        rand_ops();
        n = 0;
        do begin
            check("switch_ctrl", 64'(pe_ctrl_o), 64'(M_NTT));
            tick();
            n++;
        end while (!last_acc && n < 40);
        req_valid_i = 1'b0;
        check("switch_acc", 64'(last_acc), 64'(1));
        check("switch_infl", 64'(acc_infl0), 64'(0));
        check("switch_waited", 64'(n > 3), 64'(1));
        check("switch_newctrl", 64'(pe_ctrl_o), 64'(M_ADDSUB));
        drain("switch_drain");

        // response back-pressure: credits cap acceptance at 8
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_mode_i  = M_ADDSUB;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 12; i++) begin
            rand_ops();
            tick();
            if (last_acc) cnt++;
        end
        check("bp_acc", 64'(cnt), 64'(8));
        #1;
        check("bp_ready", 64'(req_ready_o), 64'(0));
        check("bp_full", 64'(fifo_q.size()), 64'(8));
        @(negedge clk);
        req_valid_i = 1'b0;
        p0 = pops;
        drain("bp_drain");
        check("bp_pops", 64'(pops - p0), 64'(8));

        // reset with results in flight; late PE results must be dropped
        req_valid_i = 1'b1;
        req_mode_i  = M_NTT;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            tick();
        end
        apply_reset();
        late = 0;
        for (int i = 0; i < 12; i++) begin
            if (pe_valid_i) late++;
            tick();
        end
        check("late_seen", 64'(late > 0), 64'(1));
        check("late_rsp", 64'(rsp_valid_o), 64'(0));
        check("late_busy", 64'(busy_o), 64'(0));

        // PE that never answers
        stub = 1'b1;
        send(M_ADDSUB, 1, 1, 0);
        n = 1;
        while (!err_timeout_o && n < 40) begin
            tick();
            n++;
        end
`ifdef PE_ISSUE_TIMEOUT_EN
        check("wd_rise", 64'(n), 64'(17));
        repeat (5) tick();
        check("wd_sticky", 64'(err_timeout_o), 64'(1));
`else
        check("wd_cycles", 64'(n), 64'(40));
        check("wd_off", 64'(err_timeout_o), 64'(0));
`endif
        stub = 1'b0;
        apply_reset();
        repeat (8) tick();

        // randomized traffic against the reference queues
        cnt = 0;
        rm = M_NTT;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) rm = 3'($urandom_range(0, 4));
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_mode_i  = rm;
            rand_ops();
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) cnt++;
        end
        check("rand_some_acc", 64'(cnt > 100), 64'(1));
        drain("rand_drain");
        check("rand_err", 64'(err_timeout_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d expected=%0d", cyc, 0);
        $fatal(1);
    end

endmodule

// File: doc/pe_issue_ctrl.md
PE_ISSUE_CTRL -- requirements
Module: pe_issue_ctrl

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 req_valid_i / req_ready_o  in/out  1  operand request handshake; transfer when both are high.
REQ-004 req_mode_i  in  pe_mode_e  requested PE mode.
REQ-005 req_a_i, req_b_i, req_w_i  in  coeff_t  operands A, B, twiddle W.
REQ-006 pe_a0_o, pe_b0_o, pe_w0_o  out  coeff_t  registered operands to the PE.
REQ-007 pe_ctrl_o  out  pe_mode_e  PE mode; equals the cur_mode register.
REQ-008 pe_valid_o  out  1  operand valid to the PE.
REQ-009 pe_u0_i, pe_v0_i, pe_valid_i  in  coeff_t/coeff_t/1  PE result return.
REQ-010 rsp_valid_o / rsp_ready_i  out/in  1  result handshake; transfer when both are high.
REQ-011 rsp_u_o, rsp_v_o  out  coeff_t  result pair at FIFO head.
REQ-012 busy_o  out  1  high when state is not IDLE, inflight is nonzero, or the FIFO is non-empty.
REQ-013 err_timeout_o  out  1  sticky watchdog flag.

Function
REQ-014 The block SHALL use FSM states IDLE, RUN and DRAIN, plus a cur_mode register.
REQ-015 In IDLE, the block SHALL set req_ready_o to credit_ok and SHALL NOT compare modes; on accept, cur_mode <= req_mode_i and the state -> RUN.
REQ-016 In RUN, req_ready_o SHALL equal credit_ok AND (req_mode_i == cur_mode); if req_valid_i is high with a different mode, the state -> DRAIN in that same cycle and nothing is accepted.
REQ-017 In DRAIN, req_ready_o SHALL be 0 and cur_mode SHALL hold; when inflight == 0, the state -> IDLE.
REQ-018 In RUN with req_valid_i low and inflight == 0, the state SHALL -> IDLE.
REQ-019 On accept, operands SHALL be registered into pe_*_o with pe_valid_o = 1 on the next cycle; otherwise pe_valid_o = 0 and pe_*_o hold their values.
REQ-020 pe_ctrl_o SHALL change only while inflight == 0, so that no PE result is ever in flight under a different mode.
REQ-021 inflight SHALL be a 4-bit counter: +1 on accept, -1 on pe_valid_i, and unchanged when both occur in the same cycle.
REQ-022 The response FIFO SHALL hold 8 entries of {u, v}, push on pe_valid_i, pop on rsp_valid_o & rsp_ready_i, and preserve order.
REQ-023 credit_ok SHALL be (inflight + fifo_count) < 8, so the FIFO can never overflow.
REQ-024 rsp_valid_o SHALL be high when the FIFO is non-empty; rsp_u_o/rsp_v_o SHALL be the head entry and stay stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-025 A simultaneous push and pop SHALL leave fifo_count unchanged and be legal when full or empty.
REQ-026 A pe_valid_i arriving while inflight == 0 SHALL be dropped: no push, no counter change.
REQ-027 Latency from accept to rsp_valid_o SHALL be 1 + PE latency + 1 cycles (ADDSUB 3, CODECO 5, NTT/INTT/CWM 6).
REQ-028 Sustained throughput SHALL be one request per cycle while the mode is unchanged and rsp_ready_i is held high.

Reset
REQ-029 On rst low, the block SHALL asynchronously set state = IDLE, cur_mode = PE_MODE_ADDSUB, inflight = 0, FIFO empty, and all outputs to 0 except pe_ctrl_o = PE_MODE_ADDSUB.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and queued results; PE results returning after reset release SHALL be dropped per REQ-026.

Configuration
REQ-031 With PE_ISSUE_TIMEOUT_EN defined, a 5-bit watchdog SHALL count cycles with inflight > 0 and no pe_valid_i, clear on any pe_valid_i or when inflight == 0, and set err_timeout_o at count 16.
REQ-032 Once set, err_timeout_o SHALL stay high until reset.
REQ-033 Without PE_ISSUE_TIMEOUT_EN, err_timeout_o SHALL be tied to 0 and no watchdog logic SHALL exist.

Verification (q = 3329, real pe0 attached)
REQ-034 ADDSUB: a=5, b=3 -> rsp u=8, v=2, with rsp_valid_o rising 3 cycles after accept.
REQ-035 NTT: a=1, b=2, w=3 -> u=7, v=3324 at 6 cycles; 20 back-to-back requests return in order, one per cycle.
REQ-036 In RUN/NTT with 3 in flight, an ADDSUB request arrives -> req_ready_o stays 0 until the last NTT result returns, pe_ctrl_o is unchanged throughout, and the ADDSUB request is accepted from IDLE afterwards.
REQ-037 rsp_ready_i held at 0 while 12 ADDSUB requests are offered -> exactly 8 accepted, req_ready_o low afterwards, no data lost; releasing rsp_ready_i drains all 8 in order.
REQ-038 rst pulsed low with 4 results in flight -> outputs are 0 immediately, and the late PE results are dropped with rsp_valid_o staying 0.
REQ-039 With the macro defined, a stubbed PE that never returns a result -> err_timeout_o rises 16 cycles after issue and stays high; without the macro it stays 0.
